mem_arbiter: RTL

- Two-requester arbiter in front of the single-ported Memory block (addr/MemWrite/WD/RD, keyboard register mapped at 32'h00003FFF) of the multi-cycle processor.
- Port 0 is the CPU memory interface. Port 1 is a peripheral/DMA engine, e.g. keyboard-buffer drain or display refresh.
- Runs a req/ack handshake per port, round-robin arbitration, a fixed-length access window, and registered read data.

---
 rtl/mem_arbiter.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of the single-ported Memory block.
// Optional macro ARB_LOCK_EN adds m0_lock for up to two back-to-back port 0 accesses.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int HOLD_CYCLES = 1
) (
    input  logic          clk,
    input  logic          reset,
`ifdef ARB_LOCK_EN
    input  logic          m0_lock,
`endif
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] addr,
    output logic          MemWrite,
    output logic [DW-1:0] WD,
    input  logic [DW-1:0] RD,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(HOLD_CYCLES - 1);

    state_t     state_r;
    state_t     next_state_s;
    logic [3:0] cnt_r;
    logic [3:0] next_cnt_s;
    logic       last_r;
    logic       next_last_s;
    logic       elig0_s;
    logic       elig1_s;
    logic       pick0_s;
    logic       pick1_s;
    logic       ack0_s;
    logic       ack1_s;
    logic       ld0_s;
    logic       ld1_s;
`ifdef ARB_LOCK_EN
    logic       hold_s;
    logic       prio_r;
    logic       next_prio_s;
    logic       used_r;
    logic       next_used_s;
`endif

    // A port is not eligible in the cycle of its own ack pulse.
    assign elig0_s = m0_req & ~m0_ack;
    assign elig1_s = m1_req & ~m1_ack;
    assign busy    = (state_r != IDLE);

    // Arbitration decision taken in IDLE.
    always_comb begin
        pick0_s = 1'b0;
        pick1_s = 1'b0;
`ifdef ARB_LOCK_EN
        hold_s  = 1'b0;
        // Locked port 0 keeps priority through its ack cycle and the next IDLE cycle.
        if (prio_r && (elig0_s || m0_ack)) begin
            pick0_s = elig0_s;
            hold_s  = ~elig0_s;
        end else
`endif
        if (elig0_s && (!elig1_s || last_r)) begin
            pick0_s = 1'b1;
        end else if (elig1_s) begin
            pick1_s = 1'b1;
        end else begin
            pick1_s = 1'b0;
        end
    end

    // Next-state logic and combinational memory-side outputs.
    always_comb begin
        next_state_s = state_r;
        next_cnt_s   = cnt_r;
        next_last_s  = last_r;
        ack0_s       = 1'b0;
        ack1_s       = 1'b0;
        ld0_s        = 1'b0;
        ld1_s        = 1'b0;
        addr         = '0;
        WD           = '0;
        MemWrite     = 1'b0;
`ifdef ARB_LOCK_EN
        next_prio_s  = prio_r;
        next_used_s  = used_r;
`endif
        case (state_r)
            IDLE: begin
                if (pick0_s) begin
                    next_state_s = GRANT0;
                    next_cnt_s   = 4'd0;
                    next_last_s  = 1'b0;
                end else if (pick1_s) begin
                    next_state_s = GRANT1;
                    next_cnt_s   = 4'd0;
                    next_last_s  = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
`ifdef ARB_LOCK_EN
                if (hold_s) begin
                    next_prio_s = prio_r;
                end else begin
                    next_prio_s = 1'b0;
                end
                if (prio_r && !pick0_s && !hold_s) begin
                    next_used_s = 1'b0;
                end else begin
                    next_used_s = used_r;
                end
`endif
            end
            GRANT0: begin
                addr = m0_addr;
                WD   = m0_wdata;
                if (cnt_r == LAST_CNT) begin
                    MemWrite     = m0_we;
                    ack0_s       = 1'b1;
                    ld0_s        = ~m0_we;
                    next_state_s = IDLE;
`ifdef ARB_LOCK_EN
                    // Second locked access ends the lock so round-robin resumes.
                    if (m0_lock && !used_r) begin
                        next_prio_s = 1'b1;
                        next_used_s = 1'b1;
                    end else begin
                        next_prio_s = 1'b0;
                        next_used_s = 1'b0;
                    end
`endif
                end else begin
                    next_cnt_s = cnt_r + 4'd1;
                end
            end
            GRANT1: begin
                addr = m1_addr;
                WD   = m1_wdata;
                if (cnt_r == LAST_CNT) begin
                    MemWrite     = m1_we;
                    ack1_s       = 1'b1;
                    ld1_s        = ~m1_we;
                    next_state_s = IDLE;
`ifdef ARB_LOCK_EN
                    next_prio_s  = 1'b0;
                    next_used_s  = 1'b0;
`endif
                end else begin
                    next_cnt_s = cnt_r + 4'd1;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, counters, ack pulses and read-data capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            cnt_r    <= 4'd0;
            last_r   <= 1'b1;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
`ifdef ARB_LOCK_EN
            prio_r   <= 1'b0;
            used_r   <= 1'b0;
`endif
        end else begin
            state_r <= next_state_s;
            cnt_r   <= next_cnt_s;
            last_r  <= next_last_s;
            m0_ack  <= ack0_s;
            m1_ack  <= ack1_s;
            if (ld0_s) begin
                m0_rdata <= RD;
            end
            if (ld1_s) begin
                m1_rdata <= RD;
            end
`ifdef ARB_LOCK_EN
            prio_r  <= next_prio_s;
            used_r  <= next_used_s;
`endif
        end
    end

endmodule
